// File: rtl/config_sequencer.sv
// Streams NTILES connection-block config frames in WORD-wide pieces and strobes each tile's cset.
// Define CFG_PARITY_EN to append a per-frame XOR check word (adds CHECK and ERR states).
module config_sequencer #(
  parameter int unsigned CONF_WIDTH = 288,
  parameter int unsigned WORD       = 8,
  parameter int unsigned NTILES     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CONF_WIDTH-1:0] c,
  output logic [NTILES-1:0]     cset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned WPF = (CONF_WIDTH + WORD - 1) / WORD;
  localparam int unsigned WCW = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int unsigned TW  = (NTILES > 1) ? $clog2(NTILES) : 1;

  localparam logic [WCW-1:0] LastWord = WCW'(WPF - 1);
  localparam logic [TW-1:0]  LastTile = TW'(NTILES - 1);

`ifdef CFG_PARITY_EN
  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StCommit, StDone, StErr} state_e;
  logic [WORD-1:0] acc;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StCommit, StDone} state_e;
`endif

  state_e         state;
  logic [WCW-1:0] word_cnt;
  logic [TW-1:0]  tile;

  // All outputs are registered and updated alongside the state so they always match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      word_cnt <= '0;
      tile     <= '0;
      c        <= '0;
      cset     <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef CFG_PARITY_EN
      acc      <= '0;
`endif
    end else begin
      cset <= '0;
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            state    <= StLoad;
            word_cnt <= '0;
            tile     <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StLoad: begin
          if (in_valid) begin
            // Bits of the final word that fall beyond the frame are dropped.
            for (int j = 0; j < WORD; j++) begin
              if ((32'(word_cnt) * WORD + 32'(j)) < CONF_WIDTH) begin
                c[32'(word_cnt) * WORD + 32'(j)] <= in_data[j];
              end
            end
`ifdef CFG_PARITY_EN
            acc <= (word_cnt == '0) ? in_data : (acc ^ in_data);
`endif
            if (word_cnt == LastWord) begin
`ifdef CFG_PARITY_EN
              state    <= StCheck;
`else
              state    <= StCommit;
              in_ready <= 1'b0;
              cset     <= NTILES'(1) << tile;
`endif
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
`ifdef CFG_PARITY_EN
        StCheck: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (in_data == acc) begin
              state <= StCommit;
              cset  <= NTILES'(1) << tile;
            end else begin
              state <= StErr;
              err   <= 1'b1;
            end
          end
        end
        StErr: begin
          if (start) begin
            state    <= StLoad;
            err      <= 1'b0;
            word_cnt <= '0;
            tile     <= '0;
            in_ready <= 1'b1;
          end
        end
`endif
        StCommit: begin
          if (tile == LastTile) begin
            state <= StDone;
            done  <= 1'b1;
          end else begin
            state    <= StLoad;
            tile     <= tile + 1'b1;
            word_cnt <= '0;
            in_ready <= 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: begin
          state    <= StIdle;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
